mc_ctrl_fsm: RTL

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

---
 rtl/mc_ctrl_fsm.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mc_ctrl_fsm                                                   |
// | Purpose  : Multi-cycle RV32-subset control FSM. It sequences the         |
// |            FETCH/DECODE/EXEC/MEM/WB steps, classifies the instruction,   |
// |            drives the datapath strobes and selects, traps on illegal     |
// |            encodings and counts retired instructions.                    |
// | Ports    : clk, rst (async, active-high)                                 |
// |            opcode/func3/func7  - instruction fields from IR              |
// |            mem_ready           - memory handshake                        |
// |            br_taken            - ALU branch condition (sampled in EXEC)  |
// |            mem_req/mem_sel/mem_we, ir_we, pc_we, pc_src, reg_we, wb_sel, |
// |            alu_op, trap        - datapath controls                       |
// |            state               - current state encoding                  |
// |            instret             - retired-instruction count (wraps)       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mc_ctrl_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic [3:0]       alu_op,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JAL    = 3'd5,
    CLS_JALR   = 3'd6,
    CLS_LUI    = 3'd7
  } cls_t;

  localparam logic [6:0] c_op_r     = 7'b0110011;
  localparam logic [6:0] c_op_i     = 7'b0010011;
  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;
  localparam logic [6:0] c_op_br    = 7'b1100011;
  localparam logic [6:0] c_op_jalr  = 7'b1100111;
  localparam logic [6:0] c_op_jal   = 7'b1101111;
  localparam logic [6:0] c_op_lui   = 7'b0110111;

  localparam logic [3:0] c_alu_add = 4'b0000;
  localparam logic [3:0] c_alu_sub = 4'b0001;
  localparam logic [3:0] c_alu_and = 4'b0100;
  localparam logic [3:0] c_alu_or  = 4'b0101;
  localparam logic [3:0] c_alu_xor = 4'b0110;
  localparam logic [3:0] c_alu_sll = 4'b0111;
  localparam logic [3:0] c_alu_srl = 4'b1000;
  localparam logic [3:0] c_alu_eq  = 4'b1001;
  localparam logic [3:0] c_alu_lt  = 4'b1010;
  localparam logic [3:0] c_alu_ge  = 4'b1011;
  localparam logic [3:0] c_alu_slt = 4'b1110;

  state_t           r_state;
  state_t           w_next;
  cls_t             r_cls;
  cls_t             w_cls;
  logic [3:0]       r_alu;
  logic [3:0]       w_alu;
  logic             w_legal;
  logic [CNT_W-1:0] r_instret;

  // Shared func3 -> ALU op map for register and immediate arithmetic.
  function automatic logic [3:0] f3_alu(input logic [2:0] f3);
    case (f3)
      3'b001:  f3_alu = c_alu_sll;
      3'b010:  f3_alu = c_alu_slt;
      3'b100:  f3_alu = c_alu_xor;
      3'b101:  f3_alu = c_alu_srl;
      3'b110:  f3_alu = c_alu_or;
      3'b111:  f3_alu = c_alu_and;
      default: f3_alu = c_alu_add;
    endcase
  endfunction

  // Instruction classification; only meaningful while in DECODE.
  always_comb begin
    w_legal = 1'b0;
    w_cls   = CLS_R;
    w_alu   = c_alu_add;
    case (opcode)
      c_op_r: begin
        w_cls = CLS_R;
        w_alu = f3_alu(func3);
        case (func3)
          3'b000: begin
            // func7 only distinguishes ADD/SUB; anything else is illegal.
            if (func7 == 7'b0000000) begin
              w_legal = 1'b1;
            end else if (func7 == 7'b0100000) begin
              w_legal = 1'b1;
              w_alu   = c_alu_sub;
            end
          end
          3'b010, 3'b011: w_legal = 1'b0;
          default:        w_legal = 1'b1;
        endcase
      end
      c_op_i: begin
        w_cls   = CLS_I;
        w_alu   = f3_alu(func3);
        w_legal = (func3 != 3'b011);
      end
      c_op_load: begin
        w_cls   = CLS_LOAD;
        w_legal = (func3 <= 3'b010);
      end
      c_op_store: begin
        w_cls   = CLS_STORE;
        w_legal = (func3 <= 3'b010);
      end
      c_op_br: begin
        w_cls = CLS_BRANCH;
        case (func3)
          3'b000, 3'b001: begin w_legal = 1'b1; w_alu = c_alu_eq; end
          3'b100:         begin w_legal = 1'b1; w_alu = c_alu_lt; end
          3'b101:         begin w_legal = 1'b1; w_alu = c_alu_ge; end
          default:        w_legal = 1'b0;
        endcase
      end
      c_op_jalr: begin
        w_cls   = CLS_JALR;
        w_legal = (func3 == 3'b000);
      end
      c_op_jal: begin
        w_cls   = CLS_JAL;
        w_legal = 1'b1;
      end
      c_op_lui: begin
        w_cls   = CLS_LUI;
        w_legal = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_cls     <= CLS_R;
      r_alu     <= c_alu_add;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_cls <= w_cls;
        r_alu <= w_alu;
      end
      if (pc_we) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    mem_req = 1'b0;
    mem_sel = 1'b0;
    mem_we  = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_src  = 2'd0;
    reg_we  = 1'b0;
    wb_sel  = 2'd0;
    alu_op  = c_alu_add;
    trap    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        alu_op = r_alu;
        case (r_cls)
          CLS_BRANCH: begin
            pc_we  = 1'b1;
            pc_src = br_taken ? 2'd1 : 2'd0;
            w_next = S_FETCH;
          end
          CLS_LOAD, CLS_STORE: w_next = S_MEM;
          default:             w_next = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (r_cls == CLS_STORE);
        if (mem_ready) begin
          if (r_cls == CLS_STORE) begin
            pc_we  = 1'b1;
            w_next = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        w_next = S_FETCH;
        case (r_cls)
          CLS_LOAD: wb_sel = 2'd1;
          CLS_JAL:  begin wb_sel = 2'd2; pc_src = 2'd1; end
          CLS_JALR: begin wb_sel = 2'd2; pc_src = 2'd2; end
          default:  wb_sel = 2'd0;
        endcase
      end
      S_TRAP: trap = 1'b1;
      default: w_next = S_FETCH;
    endcase
    // Outputs are forced quiet for as long as reset is held, even though
    // the state register already reads FETCH.
    if (rst) begin
      mem_req = 1'b0;
      mem_sel = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      pc_src  = 2'd0;
      reg_we  = 1'b0;
      wb_sel  = 2'd0;
      alu_op  = c_alu_add;
      trap    = 1'b0;
    end
  end

  assign state   = r_state;
  assign instret = r_instret;

endmodule
`default_nettype wire
